// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART register-command controller.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR,
    DH,
    DL,
    CHK,
    WR,
    RD,
    TX_HDR,
    TX_DH,
    TX_DL
  } state_t;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  // Bits needed to hold a down-counter preloaded with max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_gap_timer.sv
// Down-counter timeout: load restarts it, en lets it run; expire is a one-cycle pulse
// in the cycle the count would reach zero. A load in that same cycle suppresses expiry.
module uart_gap_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOAD_VAL = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [WIDTH-1:0] LOAD_CNT = WIDTH'(LOAD_VAL);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_CNT;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - ONE;
    end
  end

  assign expire = en && !load && (cnt_q == ONE);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses A5/CMD/ADDR/DH/DL/CHK frames into register writes/reads; write strobe 1 cycle after CHK.
// Read responses are sent as A5,DH,DL on a valid/ready stream held until accepted.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FRAC = 50,
  parameter int unsigned GAP_US   = 1000,
  parameter int unsigned RD_WAIT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_err,
  output logic        o_reg_wr,
  output logic        o_reg_rd,
  output logic [7:0]  o_reg_addr,
  output logic [15:0] o_reg_wdata,
  input  logic [15:0] i_reg_rdata,
  input  logic        i_reg_rvalid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_frame_ok,
  output logic        o_frame_err
);

  localparam int unsigned GAP_CNT = CLK_FRAC * GAP_US / 10;
  localparam int unsigned GAP_W   = cnt_width(GAP_CNT);
  localparam int unsigned RD_W    = cnt_width(RD_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  xor_q;
  logic [7:0]  cmd_q;
  logic [15:0] rdata_q;
  logic        wr_d, rd_d, ok_d, err_d;
  logic        gap_en, gap_exp, rd_en, rd_exp;
  logic        hdr_hit, rx_acc, tx_hs;

  assign gap_en     = state_q inside {CMD, ADDR, DH, DL};
  assign rd_en      = (state_q == RD);
  assign hdr_hit    = (state_q == IDLE) && i_rx_valid && (i_rx_data == HDR_BYTE);
  assign rx_acc     = gap_en && i_rx_valid && !i_rx_err;
  assign o_tx_valid = state_q inside {TX_HDR, TX_DH, TX_DL};
  assign tx_hs      = o_tx_valid && i_tx_ready;

  uart_gap_timer #(
    .WIDTH    (GAP_W),
    .LOAD_VAL (GAP_CNT)
  ) u_gap_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (i_rx_valid),
    .en     (gap_en),
    .expire (gap_exp)
  );

  // Same timer reused as the read-response watchdog, armed as RD is entered.
  uart_gap_timer #(
    .WIDTH    (RD_W),
    .LOAD_VAL (RD_WAIT)
  ) u_rd_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (rd_d),
    .en     (rd_en),
    .expire (rd_exp)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (hdr_hit) state_d = CMD;
      CMD, ADDR, DH, DL, CHK: begin
        if (i_rx_err) begin
          err_d = 1'b1;
        end else if (i_rx_valid) begin
          case (state_q)
            CMD: begin
              if ((i_rx_data == CMD_WRITE) || (i_rx_data == CMD_READ)) state_d = ADDR;
              else err_d = 1'b1;
            end
            ADDR: state_d = DH;
            DH:   state_d = DL;
            DL:   state_d = CHK;
            default: begin
              if (i_rx_data != xor_q) begin
                err_d = 1'b1;
              end else if (cmd_q == CMD_WRITE) begin
                state_d = WR;
                wr_d    = 1'b1;
                ok_d    = 1'b1;
              end else begin
                state_d = RD;
                rd_d    = 1'b1;
              end
            end
          endcase
        end else if (gap_exp) begin
          err_d = 1'b1;
        end
        if (err_d) state_d = IDLE;
      end
      WR: state_d = IDLE;
      RD: begin
        if (i_reg_rvalid) begin
          state_d = TX_HDR;
        end else if (rd_exp) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_HDR: if (tx_hs) state_d = TX_DH;
      TX_DH:  if (tx_hs) state_d = TX_DL;
      TX_DL: begin
        if (tx_hs) begin
          state_d = IDLE;
          ok_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      o_reg_wr    <= 1'b0;
      o_reg_rd    <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_reg_wr    <= wr_d;
      o_reg_rd    <= rd_d;
      o_frame_ok  <= ok_d;
      o_frame_err <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q       <= '0;
      cmd_q       <= '0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      rdata_q     <= '0;
    end else begin
      if (hdr_hit) xor_q <= '0;
      else if (rx_acc) xor_q <= xor_q ^ i_rx_data;
      if (rx_acc) begin
        case (state_q)
          CMD:     cmd_q             <= i_rx_data;
          ADDR:    o_reg_addr        <= i_rx_data;
          DH:      o_reg_wdata[15:8] <= i_rx_data;
          DL:      o_reg_wdata[7:0]  <= i_rx_data;
          default: ;
        endcase
      end
      if (rd_en && i_reg_rvalid) rdata_q <= i_reg_rdata;
    end
  end

  always_comb begin
    o_tx_data = '0;
    case (state_q)
      TX_HDR:  o_tx_data = HDR_BYTE;
      TX_DH:   o_tx_data = rdata_q[15:8];
      TX_DL:   o_tx_data = rdata_q[7:0];
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Frame-level bench for uart_cmd_ctrl with a byte-stream model and register responder.
module tb_uart_cmd_ctrl;

  localparam int CLK_FRAC = 50;
  localparam int GAP_US   = 1000;
  localparam int RD_WAIT  = 255;
  localparam int GAP_CYC  = CLK_FRAC * GAP_US / 10;
  localparam logic [7:0] HB = 8'hA5;
  localparam logic [7:0] CW = 8'h01;
  localparam logic [7:0] CR = 8'h02;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        i_rx_err = 1'b0;
  logic        o_reg_wr, o_reg_rd;
  logic [7:0]  o_reg_addr;
  logic [15:0] o_reg_wdata;
  logic [15:0] i_reg_rdata = '0;
  logic        i_reg_rvalid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_frame_ok, o_frame_err;

  uart_cmd_ctrl #(.CLK_FRAC(CLK_FRAC), .GAP_US(GAP_US), .RD_WAIT(RD_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_rx_err(i_rx_err),
    .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata), .i_reg_rvalid(i_reg_rvalid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_frame_ok(o_frame_ok), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // observation state
  logic [7:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int   rd_cnt, ok_cnt, err_cnt, both_total, stab_total;
  logic [7:0] rd_addr_last;
  time  wr_time, ok_time, err_time, last_tx_time, last_rx_time;
  logic prev_pending = 1'b0;
  logic [7:0] prev_data = '0;

  // environment controls
  int   ready_mode = 1;
  logic manual_ready = 1'b0;
  logic gen_ready = 1'b1;
  logic rd_respond = 1'b1;
  int   rd_lat = 2;
  logic [15:0] rd_value = '0;
  int   ph = 0;

  assign i_tx_ready = (ready_mode == 0) ? manual_ready : gen_ready;

  initial begin
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 3;
      case (ready_mode)
        2:       gen_ready = (ph == 0);
        3:       gen_ready = 1'($urandom_range(0, 1));
        default: gen_ready = 1'b1;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && o_reg_rd && rd_respond) begin
        repeat (rd_lat) @(posedge clk);
        #1;
        i_reg_rvalid = 1'b1;
        i_reg_rdata  = rd_value;
        @(posedge clk); #1;
        i_reg_rvalid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      if (o_reg_wr) begin
        wr_addr_q.push_back(o_reg_addr);
        wr_data_q.push_back(o_reg_wdata);
        wr_time = $time;
      end
      if (o_reg_rd) begin
        rd_cnt++;
        rd_addr_last = o_reg_addr;
      end
      if (o_tx_valid && i_tx_ready) begin
        tx_q.push_back(o_tx_data);
        last_tx_time = $time;
      end
      if (o_frame_ok) begin ok_cnt++; ok_time = $time; end
      if (o_frame_err) begin err_cnt++; err_time = $time; end
      if (o_frame_ok && o_frame_err) both_total++;
      if (prev_pending && (!o_tx_valid || (o_tx_data !== prev_data))) stab_total++;
      prev_pending = o_tx_valid && !i_tx_ready;
      prev_data    = o_tx_data;
    end
  end

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
    rd_cnt = 0; ok_cnt = 0; err_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    i_rx_data = b; i_rx_valid = 1'b1; i_rx_err = e;
    @(posedge clk);
    last_rx_time = $time;
    #1;
    i_rx_valid = 1'b0; i_rx_err = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] h, input logic [7:0] l, input logic bad);
    logic [7:0] chk;
    chk = c ^ a ^ h ^ l ^ (bad ? 8'h01 : 8'h00);
    send_byte(HB, 1'b0); send_byte(c, 1'b0); send_byte(a, 1'b0);
    send_byte(h, 1'b0);  send_byte(l, 1'b0); send_byte(chk, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    tests++; if (o_reg_wr !== 1'b0) begin fails++; $display("FAIL rst_wr: got %b expected 0", o_reg_wr); end
    tests++; if (o_reg_rd !== 1'b0) begin fails++; $display("FAIL rst_rd: got %b expected 0", o_reg_rd); end
    tests++; if (o_tx_valid !== 1'b0) begin fails++; $display("FAIL rst_txv: got %b expected 0", o_tx_valid); end
    tests++; if ({o_frame_ok, o_frame_err} !== 2'b00) begin fails++; $display("FAIL rst_status: got %b expected 00", {o_frame_ok, o_frame_err}); end
    tests++; if ({o_reg_addr, o_reg_wdata, o_tx_data} !== 32'h0) begin fails++; $display("FAIL rst_data: got %h expected 0", {o_reg_addr, o_reg_wdata, o_tx_data}); end
    // first byte is presented together with reset release
    clear_mon();
    @(posedge clk); #1;
    rst_n = 1'b1; i_rx_data = HB; i_rx_valid = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    send_byte(CW, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h0F, 1'b0);
    send_byte(8'hF0, 1'b0); send_byte(CW ^ 8'h55 ^ 8'h0F ^ 8'hF0, 1'b0);
    idle(5);
    tests++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h55)
      begin fails++; $display("FAIL first_byte_after_reset: got %0d writes expected 1 to 55", wr_addr_q.size()); end
  endtask

  task automatic test_write_fixed();
    clear_mon();
    send_frame(CW, 8'h10, 8'h12, 8'h34, 1'b0);
    idle(6);
    tests++; if (wr_addr_q.size() != 1) begin fails++; $display("FAIL wr_count: got %0d expected 1", wr_addr_q.size()); end
    else begin
      tests++; if (wr_addr_q[0] !== 8'h10) begin fails++; $display("FAIL wr_addr: got %h expected 10", wr_addr_q[0]); end
      tests++; if (wr_data_q[0] !== 16'h1234) begin fails++; $display("FAIL wr_data: got %h expected 1234", wr_data_q[0]); end
      tests++; if (wr_time - last_rx_time != 5) begin fails++; $display("FAIL wr_latency: got %0t expected 5", wr_time - last_rx_time); end
      tests++; if (ok_time != wr_time) begin fails++; $display("FAIL wr_ok_same_cycle: got %0t expected %0t", ok_time, wr_time); end
    end
    tests++; if (ok_cnt != 1 || err_cnt != 0) begin fails++; $display("FAIL wr_status: got ok=%0d err=%0d expected 1/0", ok_cnt, err_cnt); end
  endtask

  task automatic test_bad_chk();
    clear_mon();
    send_frame(CW, 8'h10, 8'h12, 8'h34, 1'b1);
    idle(6);
    tests++; if (err_cnt != 1 || ok_cnt != 0 || wr_addr_q.size() != 0)
      begin fails++; $display("FAIL bad_chk: got err=%0d ok=%0d wr=%0d expected 1/0/0", err_cnt, ok_cnt, wr_addr_q.size()); end
  endtask

  task automatic test_random_writes();
    logic [7:0] a, b;
    logic [15:0] d;
    logic bad;
    for (int n = 0; n < 6; n++) begin
      clear_mon();
      for (int j = 0; j < $urandom_range(0, 2); j++) begin
        do b = 8'($urandom); while (b == HB);
        send_byte(b, 1'b0);
      end
      a = 8'($urandom); d = 16'($urandom); bad = ($urandom_range(0, 3) == 0);
      send_frame(CW, a, d[15:8], d[7:0], bad);
      idle(6);
      tests++;
      if (bad) begin
        if (err_cnt != 1 || wr_addr_q.size() != 0)
          begin fails++; $display("FAIL rnd_wr_bad: got err=%0d wr=%0d expected 1/0", err_cnt, wr_addr_q.size()); end
      end else if (wr_addr_q.size() != 1 || wr_addr_q[0] !== a || wr_data_q[0] !== d || ok_cnt != 1) begin
        fails++;
        $display("FAIL rnd_wr: got n=%0d ok=%0d expected 1 write %h=%h", wr_addr_q.size(), ok_cnt, a, d);
      end
    end
  endtask

  task automatic test_read_fixed();
    logic [23:0] got3;
    clear_mon();
    ready_mode = 2; rd_value = 16'hBEEF; rd_lat = 3; rd_respond = 1'b1;
    send_frame(CR, 8'h20, 8'h00, 8'h00, 1'b0);
    idle(60);
    got3 = (tx_q.size() == 3) ? {tx_q[0], tx_q[1], tx_q[2]} : 24'h0;
    tests++; if (rd_cnt != 1 || rd_addr_last !== 8'h20) begin fails++; $display("FAIL rd_req: got n=%0d addr=%h expected 1/20", rd_cnt, rd_addr_last); end
    tests++; if (tx_q.size() != 3 || got3 !== 24'hA5BEEF) begin fails++; $display("FAIL rd_tx: got %0d bytes %h expected A5BEEF", tx_q.size(), got3); end
    tests++; if (ok_cnt != 1 || err_cnt != 0 || ok_time <= last_tx_time) begin fails++; $display("FAIL rd_ok: got ok=%0d err=%0d expected 1/0 after last byte", ok_cnt, err_cnt); end
    tests++; if (stab_total != 0) begin fails++; $display("FAIL rd_stable: got %0d violations expected 0", stab_total); end
    ready_mode = 1;
  endtask

  task automatic test_random_reads();
    logic [7:0] a;
    logic [23:0] got3, exp3;
    for (int n = 0; n < 4; n++) begin
      clear_mon();
      ready_mode = 3; rd_value = 16'($urandom); rd_lat = $urandom_range(8, 20);
      a = 8'($urandom);
      send_frame(CR, a, 8'($urandom), 8'($urandom), 1'b0);
      send_byte(HB, 1'b0);  // lands while busy and must be dropped
      idle(80);
      exp3 = {HB, rd_value};
      got3 = (tx_q.size() == 3) ? {tx_q[0], tx_q[1], tx_q[2]} : 24'h0;
      tests++;
      if (tx_q.size() != 3 || got3 !== exp3 || ok_cnt != 1 || err_cnt != 0 || rd_addr_last !== a)
        begin fails++; $display("FAIL rnd_rd: got %0d bytes %h ok=%0d err=%0d expected %h", tx_q.size(), got3, ok_cnt, err_cnt, exp3); end
    end
    ready_mode = 1;
  endtask

  task automatic test_unknown_cmd();
    clear_mon();
    send_byte(HB, 1'b0); send_byte(8'h03, 1'b0);
    idle(3);
    tests++; if (err_cnt != 1) begin fails++; $display("FAIL unk_cmd: got err=%0d expected 1", err_cnt); end
    send_byte(8'h10, 1'b0); send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    idle(4);
    tests++; if (wr_addr_q.size() != 0 || rd_cnt != 0 || ok_cnt != 0) begin fails++; $display("FAIL unk_cmd_quiet: got wr=%0d rd=%0d expected 0/0", wr_addr_q.size(), rd_cnt); end
  endtask

  task automatic test_gap_timeout();
    time t0;
    int  delta;
    clear_mon();
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
    send_byte(HB, 1'b0); send_byte(CW, 1'b0); send_byte(8'h10, 1'b0);
    t0 = last_rx_time;
    for (int i = 0; i < GAP_CYC + 50; i++) begin
      if (err_cnt != 0) break;
      @(posedge clk); #1;
    end
    delta = int'((err_time - t0) / 10);
    tests++; if (err_cnt != 1) begin fails++; $display("FAIL gap_err: got %0d expected 1", err_cnt); end
    else begin
      tests++; if (delta < GAP_CYC || delta > GAP_CYC + 1) begin fails++; $display("FAIL gap_time: got %0d cycles expected %0d", delta, GAP_CYC); end
    end
    idle(CLK_FRAC / 10 + 2);
    clear_mon();
    send_frame(CW, 8'h66, 8'hAB, 8'hCD, 1'b0);
    idle(6);
    tests++; if (wr_addr_q.size() != 1 || wr_data_q[0] !== 16'hABCD || err_cnt != 0)
      begin fails++; $display("FAIL gap_recover: got %0d writes err=%0d expected 1 write ABCD", wr_addr_q.size(), err_cnt); end
  endtask

  task automatic test_rx_err();
    clear_mon();
    send_byte(HB, 1'b0); send_byte(CW, 1'b0); send_byte(8'h10, 1'b1);
    idle(3);
    tests++; if (err_cnt != 1) begin fails++; $display("FAIL rxerr_flag: got %0d expected 1", err_cnt); end
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h37, 1'b0);
    idle(5);
    tests++; if (wr_addr_q.size() != 0 || ok_cnt != 0 || tx_q.size() != 0 || o_tx_valid !== 1'b0)
      begin fails++; $display("FAIL rxerr_idle: got wr=%0d ok=%0d tx=%0d expected 0", wr_addr_q.size(), ok_cnt, tx_q.size()); end
  endtask

  task automatic test_rd_timeout();
    time t0;
    int  delta;
    clear_mon();
    rd_respond = 1'b0;
    send_frame(CR, 8'h44, 8'h00, 8'h00, 1'b0);
    t0 = last_rx_time;
    for (int i = 0; i < RD_WAIT + 30; i++) begin
      if (err_cnt != 0) break;
      @(posedge clk); #1;
    end
    delta = int'((err_time - t0) / 10);
    tests++; if (err_cnt != 1 || tx_q.size() != 0 || ok_cnt != 0) begin fails++; $display("FAIL rd_to: got err=%0d tx=%0d expected 1/0", err_cnt, tx_q.size()); end
    else begin
      tests++; if (delta < RD_WAIT || delta > RD_WAIT + 1) begin fails++; $display("FAIL rd_to_time: got %0d expected %0d", delta, RD_WAIT); end
    end
    rd_respond = 1'b1;
    idle(4);
  endtask

  task automatic test_reset_mid_tx();
    clear_mon();
    ready_mode = 0; manual_ready = 1'b0; rd_value = 16'hC3D4; rd_lat = 2;
    send_frame(CR, 8'h30, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (o_tx_valid) break;
      @(posedge clk); #1;
    end
    tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== HB) begin fails++; $display("FAIL mid_hdr: got v=%b d=%h expected 1/A5", o_tx_valid, o_tx_data); end
    manual_ready = 1'b1;
    @(posedge clk); #1;
    manual_ready = 1'b0;
    idle(2);
    tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hC3) begin fails++; $display("FAIL mid_dh_hold: got v=%b d=%h expected 1/C3", o_tx_valid, o_tx_data); end
    rst_n = 1'b0;
    #2;
    tests++; if ({o_tx_valid, o_reg_wr, o_reg_rd, o_frame_ok, o_frame_err} !== 5'b0 || {o_reg_addr, o_reg_wdata, o_tx_data} !== 32'h0)
      begin fails++; $display("FAIL mid_rst_vals: got %b %h expected 0", {o_tx_valid, o_reg_wr, o_reg_rd, o_frame_ok, o_frame_err}, {o_reg_addr, o_reg_wdata, o_tx_data}); end
    idle(3);
    rst_n = 1'b1; ready_mode = 1;
    idle(20);
    tests++; if (tx_q.size() != 1 || ok_cnt != 0 || err_cnt != 0 || o_tx_valid !== 1'b0)
      begin fails++; $display("FAIL mid_rst_after: got tx=%0d ok=%0d err=%0d expected 1/0/0", tx_q.size(), ok_cnt, err_cnt); end
  endtask

  task automatic test_final();
    tests++; if (both_total != 0) begin fails++; $display("FAIL ok_err_overlap: got %0d expected 0", both_total); end
    tests++; if (stab_total != 0) begin fails++; $display("FAIL tx_stable_all: got %0d expected 0", stab_total); end
  endtask

  initial begin
    both_total = 0; stab_total = 0;
    clear_mon();
    test_reset();
    test_write_fixed();
    test_bad_chk();
    test_random_writes();
    test_read_fixed();
    test_random_reads();
    test_unknown_cmd();
    test_rx_err();
    test_rd_timeout();
    test_gap_timeout();
    test_reset_mid_tx();
    test_final();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_FRAC, default 50, giving the clock frequency in 100 kHz units.
REQ-002 The block SHALL have parameter GAP_US, default 1000, giving the maximum inter-byte gap inside a frame in microseconds.
REQ-003 The block SHALL have parameter RD_WAIT, default 255, giving the maximum number of cycles to wait for i_reg_rvalid.
REQ-004 Port clk, input, 1 bit: the single clock.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port i_rx_data, input, 8 bits: received byte from the UART receiver.
REQ-007 Port i_rx_valid, input, 1 bit: one-cycle strobe qualifying i_rx_data.
REQ-008 Port i_rx_err, input, 1 bit: one-cycle parity-error strobe for the current byte.
REQ-009 Ports o_reg_wr and o_reg_rd, outputs, 1 bit each: one-cycle register write and read request strobes.
REQ-010 Port o_reg_addr, output, 8 bits: register address.
REQ-011 Port o_reg_wdata, output, 16 bits: register write data.
REQ-012 Port i_reg_rdata, input, 16 bits: register read data.
REQ-013 Port i_reg_rvalid, input, 1 bit: read data valid strobe.
REQ-014 Ports o_tx_data (output, 8 bits), o_tx_valid (output, 1 bit) and i_tx_ready (input, 1 bit): valid/ready byte stream toward the UART transmitter.
REQ-015 Ports o_frame_ok and o_frame_err, outputs, 1 bit each: one-cycle status strobes.

Function
REQ-016 The frame format SHALL be 0xA5, CMD, ADDR, DH, DL, CHK, where CHK = CMD^ADDR^DH^DL; CMD 0x01 is a write and CMD 0x02 is a read (DH/DL ignored for a read).
REQ-017 The FSM states SHALL be IDLE, CMD, ADDR, DH, DL, CHK, WR, RD, TX_HDR, TX_DH, TX_DL.
REQ-018 In IDLE, every byte other than 0xA5 SHALL be discarded silently, and 0xA5 SHALL advance to CMD.
REQ-019 Each accepted byte SHALL advance one receive state and update a running XOR, which is cleared on entry to CMD.
REQ-020 An unknown CMD byte SHALL pulse o_frame_err and return the FSM to IDLE on the same edge.
REQ-021 In CHK, a checksum mismatch SHALL pulse o_frame_err and return to IDLE; a match SHALL go to WR or RD according to CMD.
REQ-022 WR SHALL drive o_reg_wr high for exactly one cycle with the latched ADDR and {DH,DL}, pulse o_frame_ok in the same cycle, and return to IDLE; the write strobe occurs 1 cycle after the CHK byte's i_rx_valid.
REQ-023 RD SHALL drive o_reg_rd for one cycle, then wait for i_reg_rvalid and latch i_reg_rdata.
REQ-024 If RD_WAIT cycles elapse in RD without i_reg_rvalid, the block SHALL pulse o_frame_err and return to IDLE.
REQ-025 Responses SHALL be sent in the order TX_HDR (0xA5), TX_DH (rdata[15:8]), TX_DL (rdata[7:0]).
REQ-026 Each response byte SHALL be held stable with o_tx_valid high until i_tx_ready is sampled high; o_tx_valid SHALL never drop before that handshake.
REQ-027 o_frame_ok SHALL pulse on the TX_DL handshake, after which the FSM SHALL return to IDLE.
REQ-028 i_rx_err in any state from CMD through CHK SHALL pulse o_frame_err and return to IDLE; in IDLE it SHALL be ignored.
REQ-029 The gap counter SHALL be loaded with CLK_FRAC*GAP_US/10 on every i_rx_valid.
REQ-030 In states CMD through DL, gap counter expiry SHALL pulse o_frame_err and return to IDLE.
REQ-031 Bytes arriving in WR, RD or TX_* states SHALL be dropped and SHALL NOT alter the frame in progress.
REQ-032 If i_rx_valid and i_rx_err arrive in the same cycle, the error SHALL win.
REQ-033 o_frame_ok and o_frame_err SHALL never be high in the same cycle.

Reset
REQ-034 While rst_n is low, the FSM SHALL be in IDLE and o_reg_wr, o_reg_rd, o_tx_valid, o_frame_ok and o_frame_err SHALL be 0.
REQ-035 While rst_n is low, o_reg_addr, o_reg_wdata and o_tx_data SHALL be 0x00, 0x0000 and 0x00, and the XOR accumulator and both counters SHALL be cleared.
REQ-036 Reset asserted mid-frame or mid-transmit SHALL abort immediately, leaving no partial strobe after deassertion.
REQ-037 The first byte accepted after reset release SHALL be sampled at the first clk edge with rst_n high.

Structure
REQ-038 Package uart_cmd_pkg SHALL hold the state enum, the header constant 0xA5, the command codes 0x01 and 0x02, and the gap-count width function.
REQ-039 The inter-byte timeout SHALL be a sub-module uart_gap_timer (load, enable, expire pulse), reused for the RD_WAIT count.
REQ-040 The top level SHALL contain only the FSM, the latches and the XOR accumulator.

Verification
REQ-041 Bytes A5 01 10 12 34 37 -> one o_reg_wr pulse with addr 0x10 and wdata 0x1234, plus o_frame_ok.
REQ-042 Bytes A5 02 20 00 00 22 with i_reg_rdata=0xBEEF and i_tx_ready toggling 1-in-3 cycles -> tx stream A5 BE EF with data held stable, then o_frame_ok.
REQ-043 Bytes A5 01 10 12 34 36 -> o_frame_err and no o_reg_wr.
REQ-044 Bytes 00 FF A5 01 10, then silence for GAP_US+1 us -> o_frame_err; a following valid frame completes normally.
REQ-045 i_rx_err on the ADDR byte, and separately rst_n pulsed low during TX_DH -> IDLE in both cases, no further tx bytes, outputs at reset values.
